// File: rtl/parity_serial_rx.sv
// rtl/parity_serial_rx.sv - serial frame receiver with parity and framing check
//
// Purpose:
//    Receives frames of the form start(0), DATA_W data bits LSB first, one
//    parity bit (XOR of the data bits), stop(1) from an asynchronous serial
//    line. The recovered word is presented together with parity and framing
//    error flags, and data_valid pulses for one clock per delivered frame.
//
// Parameters:
//    DATA_W        data bits per frame, 1..16
//    CLKS_PER_BIT  clk cycles per serial bit, minimum 4
//
// Ports:
//    clk         in   1        system clock, rising edge
//    rst_n       in   1        asynchronous active-low reset
//    rx_in       in   1        serial line, idle high, asynchronous to clk
//    data_out    out  DATA_W   last received data word
//    data_valid  out  1        one-cycle pulse when the outputs are updated
//    parity_err  out  1        parity mismatch on the last frame
//    frame_err   out  1        stop bit sampled low on the last frame
//    busy        out  1        receiver is not idle
//
// Configuration macro:
//    STICKY_ERR_EN  when defined, parity_err and frame_err accumulate across
//                   frames and clear only on reset.

module parity_serial_rx #(
   parameter int DATA_W       = 4,
   parameter int CLKS_PER_BIT = 868
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              rx_in,
   output logic [DATA_W-1:0] data_out,
   output logic              data_valid,
   output logic              parity_err,
   output logic              frame_err,
   output logic              busy
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam int BIT_W = $clog2(DATA_W + 1);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_t;

   state_t            state;
   logic              rx_meta;
   logic              rx_s;
   logic [CNT_W-1:0]  baud_cnt;
   logic [BIT_W-1:0]  bit_cnt;
   logic [DATA_W-1:0] shreg;
   logic              par_bit;
   logic              stop_bit;
   logic              stop_done;

   logic [DATA_W-1:0] shift_next;
   logic              perr_new;
   logic              ferr_new;

   // Two-flop synchronizer; resets to the idle line level so a reset never
   // looks like a start bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= rx_in;
         rx_s    <= rx_meta;
      end
   end

   // Bits arrive LSB first: each new sample enters at the MSB and the word
   // moves down, so after DATA_W samples bit 0 holds the first data bit.
   // Written as a shift of the concatenation so DATA_W = 1 needs no special case.
   always_comb begin
      shift_next = DATA_W'({rx_s, shreg} >> 1);
      perr_new   = ^{shreg, par_bit};
      ferr_new   = ~stop_bit;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         baud_cnt   <= '0;
         bit_cnt    <= '0;
         shreg      <= '0;
         par_bit    <= 1'b0;
         stop_bit   <= 1'b0;
         stop_done  <= 1'b0;
         data_out   <= '0;
         data_valid <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
         busy       <= 1'b0;
      end else begin
         data_valid <= 1'b0;

         case (state)
            IDLE: begin
               baud_cnt <= '0;
               if (!rx_s) begin
                  state <= START;
                  busy  <= 1'b1;
               end
            end

            // Re-check the line at the middle of the start bit; anything that
            // is high again by then was a glitch and is dropped silently.
            // Restarting the counter here puts every later sample mid-bit.
            START: begin
               if (baud_cnt == CNT_HALF) begin
                  baud_cnt <= '0;
                  bit_cnt  <= '0;
                  if (!rx_s) begin
                     state <= DATA;
                  end else begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end

            DATA: begin
               if (baud_cnt == CNT_LAST) begin
                  baud_cnt <= '0;
                  shreg    <= shift_next;
                  if (bit_cnt == BIT_LAST) begin
                     bit_cnt <= '0;
                     state   <= PARITY;
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end

            PARITY: begin
               if (baud_cnt == CNT_LAST) begin
                  baud_cnt <= '0;
                  par_bit  <= rx_s;
                  state    <= STOP;
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end

            // The stop bit is captured mid-bit; the outputs are published on
            // the following cycle, and the FSM is back in IDLE halfway through
            // the stop bit, ready for a back-to-back start edge.
            STOP: begin
               if (stop_done) begin
                  stop_done  <= 1'b0;
                  data_out   <= shreg;
                  data_valid <= 1'b1;
`ifdef STICKY_ERR_EN
                  parity_err <= parity_err | perr_new;
                  frame_err  <= frame_err | ferr_new;
`else
                  parity_err <= perr_new;
                  frame_err  <= ferr_new;
`endif
                  state      <= IDLE;
                  busy       <= 1'b0;
               end else if (baud_cnt == CNT_LAST) begin
                  baud_cnt  <= '0;
                  stop_bit  <= rx_s;
                  stop_done <= 1'b1;
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end

            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
